data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_arb_pkg.sv | 20 ++
 rtl/arb_select.sv | 20 ++
 rtl/data_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/data_arb_pkg.sv
// Shared types and limits for the data memory arbiter.
package data_arb_pkg;

    // Controller states: waiting for a request, or one access in flight.
    typedef enum logic {
        StIdle   = 1'b0,
        StAccess = 1'b1
    } arb_state_e;

    // Legal memory latency range and the counter width needed to hold it.
    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 4;
    localparam int unsigned CNT_W       = $clog2(MEM_LAT_MAX + 1);

    // Requester identifier.
    typedef logic id_t;
    localparam id_t ID_M0 = 1'b0;
    localparam id_t ID_M1 = 1'b1;

endpackage

// File: rtl/arb_select.sv
// Two-requester grant selection; ptr names the requester that wins on contention.
module arb_select
    import data_arb_pkg::*;
(
    input  logic [1:0] req,
    input  id_t        ptr,
    output logic [1:0] gnt
);

    // One-hot grant: a lone requester always wins, contention resolved by ptr.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (ptr == ID_M1) ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-master data memory arbiter: one access in flight, fixed MEM_LAT-cycle memory.
// Build option: define DATA_ARB_RR_EN for round-robin arbitration; otherwise m0 has
// fixed priority on contention.
module data_mem_arbiter
    import data_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_done,
    output logic          m1_done,
    output logic [DW-1:0] rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    // Out-of-range latencies are clamped into the supported window.
    localparam int unsigned LAT = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                                  (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    id_t              id_q, id_d;
    logic             mem_we_q, mem_we_d;
    logic [1:0]       done_q, done_d;
    logic [DW-1:0]    rdata_q, rdata_d;

    logic [1:0]       sel;
    logic [1:0]       gnt_vec;
    id_t              ptr;

    arb_select u_arb_select (
        .req (sel_req()),
        .ptr (ptr),
        .gnt (sel)
    );

    function automatic logic [1:0] sel_req();
        return {m1_req, m0_req};
    endfunction

    // Grants only while idle and out of reset, so nothing is accepted during reset.
    assign gnt_vec = (state_q == StIdle && !reset) ? sel : 2'b00;

`ifdef DATA_ARB_RR_EN
    id_t ptr_q, ptr_d;

    // Favour the requester not granted most recently.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vec != 2'b00) begin
            ptr_d = gnt_vec[0] ? ID_M1 : ID_M0;
        end
    end

    // Round-robin pointer register, starts favouring m0.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= ID_M0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = ID_M0;
`endif

    // Next-state: latch the winner on grant, count down the access, finish with done.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        id_d     = id_q;
        rdata_d  = rdata_q;
        mem_we_d = 1'b0;
        done_d   = 2'b00;
        unique case (state_q)
            StIdle: begin
                if (gnt_vec != 2'b00) begin
                    state_d  = StAccess;
                    cnt_d    = CNT_W'(LAT);
                    id_d     = gnt_vec[1] ? ID_M1 : ID_M0;
                    we_d     = gnt_vec[1] ? m1_we    : m0_we;
                    addr_d   = gnt_vec[1] ? m1_addr  : m0_addr;
                    wdata_d  = gnt_vec[1] ? m1_wdata : m0_wdata;
                    // Write strobe only in the first access cycle.
                    mem_we_d = gnt_vec[1] ? m1_we    : m0_we;
                end
            end
            StAccess: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = StIdle;
                    done_d[id_q] = 1'b1;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; synchronous reset aborts any access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            id_q     <= ID_M0;
            mem_we_q <= 1'b0;
            done_q   <= 2'b00;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            id_q     <= id_d;
            mem_we_q <= mem_we_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
        end
    end

    assign m0_gnt    = gnt_vec[0];
    assign m1_gnt    = gnt_vec[1];
    assign m0_done   = done_q[0];
    assign m1_done   = done_q[1];
    assign rdata     = rdata_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q == StAccess);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench: instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=3.
module tb_data_mem_arbiter;

`ifdef DATA_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic [1:0]       reset_v;
    logic             mem_clr;
    logic [1:0]       m0_req, m1_req, m0_we, m1_we;
    logic [1:0][31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [1:0]       m0_gnt, m1_gnt, m0_done, m1_done, busy, mem_we;
    logic [1:0][31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Contents of never-written memory words.
    function automatic logic [31:0] dflt(logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : (32'hA500_0000 | a);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned Lat = (g == 0) ? 1 : 3;
        logic [31:0] mem [64];
        logic        wr  [64];

        data_mem_arbiter #(.MEM_LAT(Lat), .AW(32), .DW(32)) u_dut (
            .clk       (clk),
            .reset     (reset_v[g]),
            .m0_req    (m0_req[g]),
            .m0_we     (m0_we[g]),
            .m0_addr   (m0_addr[g]),
            .m0_wdata  (m0_wdata[g]),
            .m1_req    (m1_req[g]),
            .m1_we     (m1_we[g]),
            .m1_addr   (m1_addr[g]),
            .m1_wdata  (m1_wdata[g]),
            .m0_gnt    (m0_gnt[g]),
            .m1_gnt    (m1_gnt[g]),
            .m0_done   (m0_done[g]),
            .m1_done   (m1_done[g]),
            .rdata     (rdata[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g])
        );

        assign mem_rdata[g] = wr[mem_addr[g][7:2]] ? mem[mem_addr[g][7:2]] : dflt(mem_addr[g]);

        always @(posedge clk) begin
            if (mem_clr) begin
                for (int i = 0; i < 64; i++) wr[i] <= 1'b0;
            end else if (mem_we[g]) begin
                mem[mem_addr[g][7:2]] <= mem_wdata[g];
                wr[mem_addr[g][7:2]]  <= 1'b1;
            end
        end
    end

    // flags = {m0_gnt, m1_gnt, m0_done, m1_done, busy, mem_we}; req/we = {m1, m0}
    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] wd;
        logic [5:0]  flags;
        logic [31:0] rd;
        logic [31:0] ma;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] req, logic [1:0] we, logic [31:0] a0,
                                logic [31:0] a1, logic [31:0] wd, logic [5:0] flags,
                                logic [31:0] rd, logic [31:0] ma);
        vec_t v;
        v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.wd = wd;
        v.flags = flags; v.rd = rd; v.ma = ma;
        return v;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] WD = 32'h12345678;

    initial begin
        reset_v = 2'b11; mem_clr = 1'b1;
        m0_req = '0; m1_req = '0; m0_we = '0; m1_we = '0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;

        // Single read, write, read-back, request during access, 4-way contention.
        tbl.push_back(mk(2'b00, 2'b00, 0,     0,     0,  6'b000000, 0,  0));
        tbl.push_back(mk(2'b01, 2'b00, 32'h10, 0,    0,  6'b100000, 0,  0));
        tbl.push_back(mk(2'b00, 2'b00, 0,     0,     0,  6'b000010, 0,  32'h10));
        tbl.push_back(mk(2'b10, 2'b10, 0,     32'h20, WD, 6'b011000, DB, 32'h10));
        tbl.push_back(mk(2'b00, 2'b00, 0,     0,     0,  6'b000011, DB, 32'h20));
        tbl.push_back(mk(2'b01, 2'b00, 32'h20, 0,    0,  6'b100100, DB, 32'h20));
        tbl.push_back(mk(2'b10, 2'b00, 0,     32'h10, 0, 6'b000010, DB, 32'h20));
        tbl.push_back(mk(2'b10, 2'b00, 0,     32'h10, 0, 6'b011000, WD, 32'h20));
        tbl.push_back(mk(2'b00, 2'b00, 0,     0,     0,  6'b000010, WD, 32'h10));
        tbl.push_back(mk(2'b11, 2'b00, 32'h10, 32'h20, 0, 6'b100100, DB, 32'h10));
        tbl.push_back(mk(2'b11, 2'b00, 32'h10, 32'h20, 0, 6'b000010, DB, 32'h10));
        tbl.push_back(mk(2'b11, 2'b00, 32'h10, 32'h20, 0,
                         RR ? 6'b011000 : 6'b101000, DB, 32'h10));
        tbl.push_back(mk(2'b11, 2'b00, 32'h10, 32'h20, 0, 6'b000010, DB,
                         RR ? 32'h20 : 32'h10));
        tbl.push_back(mk(2'b11, 2'b00, 32'h10, 32'h20, 0,
                         RR ? 6'b100100 : 6'b101000, RR ? WD : DB, RR ? 32'h20 : 32'h10));
        tbl.push_back(mk(2'b11, 2'b00, 32'h10, 32'h20, 0, 6'b000010,
                         RR ? WD : DB, 32'h10));
        tbl.push_back(mk(2'b11, 2'b00, 32'h10, 32'h20, 0,
                         RR ? 6'b011000 : 6'b101000, DB, 32'h10));
        tbl.push_back(mk(2'b00, 2'b00, 0,     0,     0,  6'b000010, DB,
                         RR ? 32'h20 : 32'h10));
        tbl.push_back(mk(2'b00, 2'b00, 0,     0,     0,
                         RR ? 6'b000100 : 6'b001000, RR ? WD : DB, RR ? 32'h20 : 32'h10));

        next_cycle();
        next_cycle();
        reset_v = 2'b00; mem_clr = 1'b0;

        // Reset state of the MEM_LAT=3 instance.
        #2;
        chk("lat3_reset", {m0_gnt[1], m1_gnt[1], m0_done[1], m1_done[1], busy[1], mem_we[1],
                           rdata[1], mem_addr[1], mem_wdata[1]}, '0);

        foreach (tbl[i]) begin
            m0_req[0] = tbl[i].req[0]; m1_req[0] = tbl[i].req[1];
            m0_we[0]  = tbl[i].we[0];  m1_we[0]  = tbl[i].we[1];
            m0_addr[0] = tbl[i].a0;    m1_addr[0] = tbl[i].a1;
            m0_wdata[0] = tbl[i].wd;   m1_wdata[0] = tbl[i].wd;
            #2;
            chk($sformatf("vec%0d", i),
                {m0_gnt[0], m1_gnt[0], m0_done[0], m1_done[0], busy[0], mem_we[0],
                 rdata[0], mem_addr[0]},
                {tbl[i].flags, tbl[i].rd, tbl[i].ma});
            next_cycle();
        end

        // MEM_LAT=3 back-to-back reads: gnt 0/4, done 4/8, busy 1-3 and 5-7.
        for (int c = 0; c < 10; c++) begin
            m0_req[1]  = (c <= 4);
            m0_we[1]   = 1'b0;
            m0_addr[1] = (c == 0) ? 32'h40 : 32'h44;
            #2;
            chk($sformatf("lat3_b2b_c%0d", c),
                {m0_gnt[1], m1_gnt[1], m0_done[1], m1_done[1], busy[1]},
                {c == 0 || c == 4, 1'b0, c == 4 || c == 8, 1'b0, (c % 4) != 0 && c < 8});
            if (c == 4) chk("lat3_rdata0", rdata[1], dflt(32'h40));
            if (c == 8) chk("lat3_rdata1", rdata[1], dflt(32'h44));
            next_cycle();
        end

        // MEM_LAT=3 write aborted by reset in its second access cycle.
        m0_req[1] = 1'b1; m0_we[1] = 1'b1; m0_addr[1] = 32'h48; m0_wdata[1] = 32'hCAFEF00D;
        #2;
        chk("abort_gnt", m0_gnt[1], 1'b1);
        next_cycle();
        m0_req[1] = 1'b0; m0_we[1] = 1'b0;
        #2;
        chk("abort_we1", {busy[1], mem_we[1]}, 2'b11);
        next_cycle();
        reset_v[1] = 1'b1;
        #2;
        chk("abort_we2", mem_we[1], 1'b0);
        next_cycle();
        reset_v[1] = 1'b0;
        #2;
        chk("abort_zero", {m0_gnt[1], m1_gnt[1], m0_done[1], m1_done[1], busy[1], mem_we[1],
                           rdata[1], mem_addr[1], mem_wdata[1]}, '0);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            #2;
            chk($sformatf("abort_quiet%0d", c),
                {m0_done[1], m1_done[1], mem_we[1], busy[1]}, 4'b0000);
        end

        // Arbiter still works after the abort: the one committed write is readable.
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            m0_req[1] = (c == 0); m0_addr[1] = 32'h48;
            #2;
            if (c == 0) chk("post_gnt", m0_gnt[1], 1'b1);
            if (c == 4) chk("post_read", {m0_done[1], rdata[1]}, {1'b1, 32'hCAFEF00D});
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
